ssp_param: RTL
==============

Name: ssp_param

Overview:
Parametrised synchronous serial port, the next generation of the team's fixed 8-bit SSP. It provides an APB-style push/pop host side, TX and RX FIFOs of configurable depth and word width, and a programmable serial clock divider. It generates watermark-based interrupts, a sticky RX overrun flag, and exposes FIFO fill levels. Everything runs in the single pclk domain; the incoming serial clock and frame signals are synchronised into it.

Parameters:
- DATA_W, 8, serial word width in bits (4..16).
- FIFO_DEPTH, 4, entries per FIFO; power of 2, ≥2.
- CLK_DIV, 2, pclk cycles per ssp_clk_out half-period; ≥1.
- TX_WM, 1, ssptxintr asserts when tx_level ≤ TX_WM.
- RX_WM, 1, ssprxintr asserts when rx_level ≥ RX_WM.

Ports:
- pclk, in, 1: clock.
- clr_b, in, 1: asynchronous active-low reset.
- psel, in, 1: host select.
- pwrite, in, 1: 1 = write (push TX), 0 = read (pop RX).
- pwdata, in, DATA_W: TX push data.
- prdata, out, DATA_W: RX FIFO head.
- ssp_clk_in, in, 1: external serial clock.
- ssp_fss_in, in, 1: external frame sync.
- ssp_rxd, in, 1: serial receive data.
- ssp_clk_out, out, 1: generated serial clock.
- ssp_fss_out, out, 1: frame sync out.
- ssp_txd, out, 1: serial transmit data.
- ssp_oe_b, out, 1: TX output enable, active-low.
- ssptxintr, out, 1: TX watermark interrupt.
- ssprxintr, out, 1: RX watermark interrupt.
- rx_overrun, out, 1: sticky overrun flag.
- tx_level, out, $clog2(FIFO_DEPTH+1): TX fill count.
- rx_level, out, $clog2(FIFO_DEPTH+1): RX fill count.

Behaviour:
- Reset (clr_b low, async): FIFOs empty, levels 0, ssp_clk_out=0, ssp_fss_out=0, ssp_txd=0, ssp_oe_b=1, rx_overrun=0, prdata=0, TX FSM=IDLE, RX FSM=WAIT. With TX_WM≥0 this gives ssptxintr=1 and ssprxintr=0 out of reset.
- Host side:
  - psel&pwrite pushes pwdata on the pclk edge; ignored when TX full.
  - psel&!pwrite pops RX on the pclk edge; ignored when RX empty.
  - prdata is the combinational RX head; it is 0 when RX is empty.
  - Push and pop in the same cycle on the same FIFO (a full or empty FIFO included) both succeed; the level is unchanged.
- Divider: free-running counter toggles ssp_clk_out every CLK_DIV pclk cycles; the period is 2*CLK_DIV pclk cycles. All TX actions occur in the pclk cycle where ssp_clk_out rises ("tick").
- TX FSM: IDLE → SYNC → SHIFT.
  - IDLE: on a tick with TX non-empty, pop the head into the shift register and go to SYNC; ssp_fss_out=1 for one serial period.
  - SYNC: on the next tick go to SHIFT; ssp_fss_out=0, ssp_oe_b=0, ssp_txd=MSB.
  - SHIFT: shift one bit per tick, MSB first, for DATA_W bits. On the tick after the last bit:
    - if TX is non-empty, pop and go directly to SYNC (back-to-back frames, oe_b stays 0);
    - otherwise go to IDLE with ssp_oe_b=1 and ssp_txd=0.
  - Host pushes during a frame never disturb the frame in flight.
- RX path:
  - ssp_clk_in, ssp_fss_in and ssp_rxd each pass through a 2-flop synchroniser.
  - A falling edge of the synchronised clock is the sample event. The external clock high and low times must each be ≥3 pclk.
  - WAIT: a sample event with fss=1 → SHIFT, bit counter cleared.
  - SHIFT: each sample event shifts rxd in, MSB first. After DATA_W bits, push the word and return to WAIT. A sample event with fss=1 on the push cycle re-arms directly.
  - If RX is full at push time, the word is dropped and rx_overrun is set. A host pop in that same cycle frees the slot, so the push succeeds and there is no overrun.
  - rx_overrun clears on the cycle after any successful RX pop.
- Pointers wrap modulo FIFO_DEPTH. Levels range 0..FIFO_DEPTH inclusive.

Optional Feature:
SSP_LOOPBACK_EN.
- Defined: adds input port lbk (1 bit). When lbk=1, the RX synchroniser inputs are taken from the internal ssp_clk_out, ssp_fss_out and ssp_txd instead of the pads, and the pad outputs remain driven.
- Undefined: no lbk port; RX always uses the pads.

Decomposition:
- Package ssp_pkg holds:
  - TX state encoding (IDLE, SYNC, SHIFT) and RX state encoding (WAIT, SHIFT);
  - the level-width function clog2(FIFO_DEPTH+1).
- Sub-module ssp_fifo: parametrised synchronous FIFO with push, pop, dout, level, full, empty. It is instantiated twice. The TX/RX FSMs and the divider stay in ssp_param.

Test Plan (DATA_W=8, FIFO_DEPTH=4, CLK_DIV=2):
- Reset → ssp_oe_b=1, ssptxintr=1, ssprxintr=0, levels 0.
- Push 0xA5 → tx_level=1, then 0 at the next tick. The frame shows fss high for 4 pclk, then txd 1,0,1,0,0,1,0,1 with 4 pclk per bit. oe_b returns to 1 after 8 bits.
- Push 0x3C and 0xC3 on consecutive cycles → two back-to-back frames; oe_b stays 0 between them and the second fss pulse immediately follows bit 0 of the first word.
- Drive an external frame with 0x5E (serial clk period 8 pclk) → rx_level=1, ssprxintr=1, prdata=0x5E. After a pop: level=0, prdata=0.
- Receive 5 words without popping → rx_level=4 and rx_overrun=1. The first 4 words are read back intact; rx_overrun=0 after the first pop.
- Push into a full TX FIFO while the FSM pops on the same cycle → level stays 4, no word is lost. With SSP_LOOPBACK_EN and lbk=1, pushing 0x81 results in RX receiving 0x81.

Source files
------------

// File: rtl/ssp_pkg.sv
// ssp_pkg: shared TX/RX state encodings and the FIFO level-width helper for ssp_param.
package ssp_pkg;
    typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_SHIFT} tx_state_e;
    typedef enum logic {RX_WAIT, RX_SHIFT} rx_state_e;
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ssp_fifo.sv
// ssp_fifo: synchronous FIFO; a push and a pop in the same cycle both proceed, even when full or empty.
module ssp_fifo import ssp_pkg::*; #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [W-1:0]              din_i,
    output logic [W-1:0]              dout_o,
    output logic [level_w(DEPTH)-1:0] level_o,
    output logic                      full_o,
    output logic                      empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [LW-1:0] lvl_q;
    logic          do_push, do_pop;
    assign full_o  = lvl_q == LW'(DEPTH);
    assign empty_o = lvl_q == '0;
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && (!empty_o || push_i);
    assign dout_o  = empty_o ? '0 : mem_q[rp_q];
    assign level_o = lvl_q;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop) rp_q <= rp_q + AW'(1);
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/ssp_param.sv
// ssp_param: parametrised synchronous serial port with host FIFOs, clock divider and TX/RX framing.
// Defining SSP_LOOPBACK_EN adds the lbk port, which feeds the RX synchronisers from the TX outputs.
module ssp_param import ssp_pkg::*; #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2,
    parameter int TX_WM      = 1,
    parameter int RX_WM      = 1
) (
    input  logic                           pclk,
    input  logic                           clr_b,
`ifdef SSP_LOOPBACK_EN
    input  logic                           lbk,
`endif
    input  logic                           psel,
    input  logic                           pwrite,
    input  logic [DATA_W-1:0]              pwdata,
    output logic [DATA_W-1:0]              prdata,
    input  logic                           ssp_clk_in,
    input  logic                           ssp_fss_in,
    input  logic                           ssp_rxd,
    output logic                           ssp_clk_out,
    output logic                           ssp_fss_out,
    output logic                           ssp_txd,
    output logic                           ssp_oe_b,
    output logic                           ssptxintr,
    output logic                           ssprxintr,
    output logic                           rx_overrun,
    output logic [level_w(FIFO_DEPTH)-1:0] tx_level,
    output logic [level_w(FIFO_DEPTH)-1:0] rx_level
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    logic [CW-1:0]     div_q;
    logic              sclk_q, tick;
    tx_state_e         tx_st_q;
    logic [DATA_W-1:0] tx_sh_q, tx_head;
    logic [BW-1:0]     tx_cnt_q;
    logic              fss_q, txd_q, oe_b_q;
    logic              tx_pop, tx_empty, unused_tx_full;
    rx_state_e         rx_st_q;
    logic [DATA_W-2:0] rx_sh_q;
    logic [BW-1:0]     rx_cnt_q;
    logic [DATA_W-1:0] rx_word;
    logic              ovr_q, rx_push, rx_pop_ok, rx_empty, rx_full;
    logic              rx_clk_src, rx_fss_src, rx_dat_src, sample;
    logic [2:0]        clk_sync_q;
    logic [1:0]        fss_sync_q, dat_sync_q;
    assign tick   = div_q == CW'(CLK_DIV - 1) && !sclk_q;
    assign tx_pop = tick && !tx_empty &&
                    (tx_st_q == TX_IDLE || (tx_st_q == TX_SHIFT && tx_cnt_q == BW'(DATA_W)));
    ssp_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(pclk), .rst_n(clr_b), .push_i(psel && pwrite), .pop_i(tx_pop), .din_i(pwdata),
        .dout_o(tx_head), .level_o(tx_level), .full_o(unused_tx_full), .empty_o(tx_empty)
    );
    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (div_q == CW'(CLK_DIV - 1)) begin
            div_q  <= '0;
            sclk_q <= !sclk_q;
        end else begin
            div_q <= div_q + CW'(1);
        end
    end
    // Every TX transition happens on the pclk edge where ssp_clk_out rises.
    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            tx_st_q  <= TX_IDLE;
            tx_sh_q  <= '0;
            tx_cnt_q <= '0;
            fss_q    <= 1'b0;
            txd_q    <= 1'b0;
            oe_b_q   <= 1'b1;
        end else if (tick) begin
            case (tx_st_q)
                TX_IDLE: if (tx_pop) begin
                    tx_sh_q <= tx_head;
                    fss_q   <= 1'b1;
                    tx_st_q <= TX_SYNC;
                end
                TX_SYNC: begin
                    fss_q    <= 1'b0;
                    oe_b_q   <= 1'b0;
                    txd_q    <= tx_sh_q[DATA_W-1];
                    tx_sh_q  <= tx_sh_q << 1;
                    tx_cnt_q <= BW'(1);
                    tx_st_q  <= TX_SHIFT;
                end
                default: if (tx_cnt_q != BW'(DATA_W)) begin
                    txd_q    <= tx_sh_q[DATA_W-1];
                    tx_sh_q  <= tx_sh_q << 1;
                    tx_cnt_q <= tx_cnt_q + BW'(1);
                end else if (tx_pop) begin
                    tx_sh_q <= tx_head;
                    fss_q   <= 1'b1;
                    txd_q   <= 1'b0;
                    tx_st_q <= TX_SYNC;
                end else begin
                    oe_b_q  <= 1'b1;
                    txd_q   <= 1'b0;
                    tx_st_q <= TX_IDLE;
                end
            endcase
        end
    end
`ifdef SSP_LOOPBACK_EN
    assign rx_clk_src = lbk ? sclk_q : ssp_clk_in;
    assign rx_fss_src = lbk ? fss_q : ssp_fss_in;
    assign rx_dat_src = lbk ? txd_q : ssp_rxd;
`else
    assign rx_clk_src = ssp_clk_in;
    assign rx_fss_src = ssp_fss_in;
    assign rx_dat_src = ssp_rxd;
`endif
    assign sample    = clk_sync_q[2] && !clk_sync_q[1];
    assign rx_word   = {rx_sh_q, dat_sync_q[1]};
    assign rx_push   = sample && rx_st_q == RX_SHIFT && rx_cnt_q == BW'(DATA_W - 1);
    assign rx_pop_ok = psel && !pwrite && (!rx_empty || rx_push);
    ssp_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(pclk), .rst_n(clr_b), .push_i(rx_push), .pop_i(psel && !pwrite), .din_i(rx_word),
        .dout_o(prdata), .level_o(rx_level), .full_o(rx_full), .empty_o(rx_empty)
    );
    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            clk_sync_q <= '0;
            fss_sync_q <= '0;
            dat_sync_q <= '0;
            rx_st_q    <= RX_WAIT;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            ovr_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], rx_clk_src};
            fss_sync_q <= {fss_sync_q[0], rx_fss_src};
            dat_sync_q <= {dat_sync_q[0], rx_dat_src};
            if (rx_pop_ok) ovr_q <= 1'b0;
            else if (rx_push && rx_full) ovr_q <= 1'b1;
            if (sample && (rx_st_q == RX_WAIT || rx_push)) begin
                rx_st_q  <= fss_sync_q[1] ? RX_SHIFT : RX_WAIT;
                rx_cnt_q <= '0;
            end else if (sample) begin
                rx_sh_q  <= rx_word[DATA_W-2:0];
                rx_cnt_q <= rx_cnt_q + BW'(1);
            end
        end
    end
    assign ssp_clk_out = sclk_q;
    assign ssp_fss_out = fss_q;
    assign ssp_txd     = txd_q;
    assign ssp_oe_b    = oe_b_q;
    assign rx_overrun  = ovr_q;
    assign ssptxintr   = int'(tx_level) <= TX_WM;
    assign ssprxintr   = int'(rx_level) >= RX_WM;
endmodule
